// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the seq_mult digit-serial multiplier controller.
package seq_mult_pkg;

    // Width of the column index k (columns 0..2N-2, up to 14).
    localparam int K_W   = 4;
    // Width of the digit indices i and j (0..MAX_DIGITS-1).
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        PREC_2    = 2'd0,
        PREC_4    = 2'd1,
        PREC_8    = 2'd2,
        PREC_RSVD = 2'd3
    } prec_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_e;

    // Signed-mode accumulator/carry preload: one set bit per operand digit.
    // Element 0 is prec 0; the reserved encoding mirrors prec 2.
    localparam logic [3:0][7:0] SIGNED_INIT = {8'hFF, 8'hFF, 8'h0F, 8'h03};

    // Operand digit count for a precision code; the reserved code runs as 8 digits.
    function automatic logic [K_W-1:0] digits_of(input prec_e prec);
        case (prec)
            PREC_2:  return 4'd2;
            PREC_4:  return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/col_walker.sv
// Product-scanning column walker: holds column index k and row index i,
// and reports the column bounds and the end of the final column.
module col_walker
    import seq_mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [K_W-1:0]   n,
    output logic [K_W-1:0]   k,
    output logic [SEL_W-1:0] i,
    output logic [SEL_W-1:0] j,
    output logic [SEL_W-1:0] imin,
    output logic             col_end,
    output logic             final_col
);

    logic [K_W-1:0]   k_next;
    logic [K_W-1:0]   imax;
    logic [K_W:0]     last_k;
    logic [SEL_W-1:0] imin_next;

    // Lowest row that still has a digit of b in column kk.
    function automatic logic [SEL_W-1:0] imin_of(input logic [K_W-1:0] kk,
                                                 input logic [K_W-1:0] nn);
        if (kk >= nn)
            return SEL_W'(kk - nn + 4'd1);
        else
            return '0;
    endfunction

    // Column bounds, partner index and column-end detection for the current k.
    always_comb begin
        k_next    = k + 4'd1;
        imin      = imin_of(k, n);
        imin_next = imin_of(k_next, n);
        imax      = (k < n) ? k : (n - 4'd1);
        j         = k[SEL_W-1:0] - i;
        col_end   = ({1'b0, i} == imax);
        last_k    = {n, 1'b0} - 5'd2;
        final_col = ({1'b0, k} == last_k);
    end

    // Step one pair per MAC cycle, jumping to the next column's first row at a column end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
            i <= '0;
        end else if (load) begin
            k <= '0;
            i <= '0;
        end else if (advance) begin
            if (col_end) begin
                k <= k_next;
                i <= imin_next;
            end else begin
                i <= i + 3'd1;
            end
        end
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequencer for the seq_mult datapath: handshake, product-scanning schedule,
// Baugh-Wooley strobes and the digit-valid/last stream.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int P          = 2,
    parameter int MAX_DIGITS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    prec,
    input  logic                          is_signed,
    output logic                          start,
    output logic [$clog2(MAX_DIGITS)-1:0] muxSelA,
    output logic [$clog2(MAX_DIGITS)-1:0] muxSelB,
    output logic                          invertFirstBit,
    output logic                          invertSecondRow,
    output logic                          countLast2,
    output logic                          countDown,
    output logic                          lastOut,
    output logic                          placeOne,
    output logic [1:0]                    countShiftInput,
    output logic [4*P-1:0]                initSum,
    output logic                          dig_valid,
    output logic                          dig_last
);

    ctrl_state_e      state, state_d;
    prec_e            prec_q;
    logic             signed_q;
    logic [K_W-1:0]   n;
    logic [K_W-1:0]   k;
    logic [SEL_W-1:0] i, j, imin;
    logic             col_end, final_col;
    logic             row_top, col_top;

    assign n = digits_of(prec_q);

    col_walker u_walker (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (start),
        .advance   (state == MAC),
        .n         (n),
        .k         (k),
        .i         (i),
        .j         (j),
        .imin      (imin),
        .col_end   (col_end),
        .final_col (final_col)
    );

    // State register plus the operation's latched precision and signedness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prec_q   <= PREC_2;
            signed_q <= 1'b0;
        end else begin
            state <= state_d;
            if (start) begin
                prec_q   <= prec_e'(prec);
                signed_q <= is_signed;
            end
        end
    end

    // Next state and Moore output decode; start and initSum follow the live request.
    always_comb begin
        state_d         = state;
        in_ready        = 1'b0;
        start           = 1'b0;
        muxSelA         = '0;
        muxSelB         = '0;
        invertFirstBit  = 1'b0;
        invertSecondRow = 1'b0;
        countLast2      = 1'b0;
        countDown       = 1'b0;
        lastOut         = 1'b0;
        placeOne        = 1'b0;
        countShiftInput = 2'b00;
        initSum         = '0;
        row_top         = ({1'b0, i} == (n - 4'd1));
        col_top         = ({1'b0, j} == (n - 4'd1));
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                start    = in_valid;
                if (in_valid) begin
                    state_d = MAC;
                    if (is_signed)
                        initSum = SIGNED_INIT[prec];
                end
            end
            MAC: begin
                muxSelA    = i;
                muxSelB    = j;
                countLast2 = col_end;
                countDown  = (k >= n);
                if (signed_q) begin
                    invertSecondRow = row_top && !col_top;
                    invertFirstBit  = col_top && !row_top;
                    placeOne        = (k == n) && (i == imin);
                end
                if (col_end && final_col)
                    state_d = FLUSH;
            end
            FLUSH: begin
                lastOut = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit stream runs one cycle behind column ends and the flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_valid <= 1'b0;
            dig_last  <= 1'b0;
        end else begin
            dig_valid <= countLast2 | lastOut;
            dig_last  <= lastOut;
        end
    end

endmodule
